// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared widths and EX control-field bit positions for the
//                MIPS pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_AW_DEF     = 5;
    localparam int WB_W_DEF       = 2;
    localparam int MEM_W_DEF      = 4;
    localparam int TAR_W_DEF      = 26;
    localparam int CNT_W_DEF      = 16;
    localparam int MEM_RD_BIT_DEF = 1;

    // EX control word layout: {AluzeroCtr[1:0], RegDst, ALUop[2:0], ALUSrc}
    localparam int EX_W       = 7;
    localparam int ALUSRC_BIT = 0;
    localparam int ALUOP_LSB  = 1;
    localparam int REGDST_BIT = 4;
    localparam int ZCTR_LSB   = 5;

endpackage
`default_nettype wire

// File: rtl/pipe_field_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_field_reg
//  Description : One pipeline field: reset, bubble (clear for control fields,
//                hold for data fields), stall hold and load.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_field_reg #(
    parameter int W             = 1,
    parameter bit CLR_ON_BUBBLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_bubble,
    input  logic         i_hold,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_field_q;
    logic [W-1:0] w_field_d;

    // A bubble outranks a hold so that a flush during a stall still kills EX.
    always_comb begin
        w_field_d = r_field_q;
        if (i_bubble) begin
            if (CLR_ON_BUBBLE) begin
                w_field_d = '0;
            end
        end else if (!i_hold) begin
            w_field_d = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_field_q <= '0;
        end else begin
            r_field_q <= w_field_d;
        end
    end

    assign o_q = r_field_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_pipe
//  Description : ID/EX pipeline register with stall, flush, valid bit,
//                saturating bubble counter and optional load-use detection
//                (enabled by defining HAZARD_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int WB_W       = WB_W_DEF,
    parameter int MEM_W      = MEM_W_DEF,
    parameter int TAR_W      = TAR_W_DEF,
    parameter int MEM_RD_BIT = MEM_RD_BIT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [WB_W-1:0]   WB_in,
    input  logic [MEM_W-1:0]  MEM_in,
    input  logic [EX_W-1:0]   EX_in,
    input  logic [DATA_W-1:0] nextAddress_in,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_AW-1:0] Ins25_in,
    input  logic [REG_AW-1:0] Ins20_in,
    input  logic [REG_AW-1:0] Ins15_in,
    input  logic [TAR_W-1:0]  tar_in,
    output logic [WB_W-1:0]   WB_out,
    output logic [MEM_W-1:0]  MEM_out,
    output logic [DATA_W-1:0] nextAddress_out,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_AW-1:0] Ins25_out,
    output logic [REG_AW-1:0] Ins20_out,
    output logic [REG_AW-1:0] Ins15_out,
    output logic [TAR_W-1:0]  tar_out,
    output logic              ex_valid,
    output logic [1:0]        AluzeroCtr,
    output logic              RegDst,
    output logic [2:0]        ALUop,
    output logic              ALUSrc,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            w_hazard;
    logic            w_bubble;
    logic [EX_W-1:0] w_ex;
    logic [CNT_W-1:0] r_bubble_cnt_q;
    logic [CNT_W-1:0] w_bubble_cnt_d;

`ifdef HAZARD_EN
    // Load in EX whose destination rt feeds the instruction now in ID.
    assign w_hazard = !reset && ex_valid && MEM_out[MEM_RD_BIT] && id_valid &&
                      (Ins20_out != '0) &&
                      ((Ins20_out == Ins25_in) || (Ins20_out == Ins20_in));
`else
    assign w_hazard = 1'b0;
`endif

    // Flush covers a coincident hazard; a stall suppresses the hazard bubble.
    assign w_bubble     = flush || (w_hazard && !stall);
    assign hazard_stall = w_hazard;

    pipe_field_reg #(.W(1), .CLR_ON_BUBBLE(1'b1)) u_valid (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(id_valid), .o_q(ex_valid));
    pipe_field_reg #(.W(WB_W), .CLR_ON_BUBBLE(1'b1)) u_wb (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(WB_in), .o_q(WB_out));
    pipe_field_reg #(.W(MEM_W), .CLR_ON_BUBBLE(1'b1)) u_mem (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(MEM_in), .o_q(MEM_out));
    pipe_field_reg #(.W(EX_W), .CLR_ON_BUBBLE(1'b1)) u_ex (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(EX_in), .o_q(w_ex));
    pipe_field_reg #(.W(DATA_W), .CLR_ON_BUBBLE(1'b0)) u_npc (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(nextAddress_in), .o_q(nextAddress_out));
    pipe_field_reg #(.W(DATA_W), .CLR_ON_BUBBLE(1'b0)) u_a (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(A_in), .o_q(A_out));
    pipe_field_reg #(.W(DATA_W), .CLR_ON_BUBBLE(1'b0)) u_b (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(B_in), .o_q(B_out));
    pipe_field_reg #(.W(DATA_W), .CLR_ON_BUBBLE(1'b0)) u_imm (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(imm_in), .o_q(imm_out));
    pipe_field_reg #(.W(REG_AW), .CLR_ON_BUBBLE(1'b0)) u_rs (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(Ins25_in), .o_q(Ins25_out));
    pipe_field_reg #(.W(REG_AW), .CLR_ON_BUBBLE(1'b0)) u_rt (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(Ins20_in), .o_q(Ins20_out));
    pipe_field_reg #(.W(REG_AW), .CLR_ON_BUBBLE(1'b0)) u_rd (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(Ins15_in), .o_q(Ins15_out));
    pipe_field_reg #(.W(TAR_W), .CLR_ON_BUBBLE(1'b0)) u_tar (
        .clk(clk), .rst(reset), .i_bubble(w_bubble), .i_hold(stall), .i_d(tar_in), .o_q(tar_out));

    assign AluzeroCtr = w_ex[ZCTR_LSB +: 2];
    assign RegDst     = w_ex[REGDST_BIT];
    assign ALUop      = w_ex[ALUOP_LSB +: 3];
    assign ALUSrc     = w_ex[ALUSRC_BIT];

    always_comb begin
        w_bubble_cnt_d = r_bubble_cnt_q;
        if (w_bubble && (r_bubble_cnt_q != C_CNT_MAX)) begin
            w_bubble_cnt_d = r_bubble_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt_q <= '0;
        end else begin
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    assign bubble_cnt = r_bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_pipe
//  Description : Self-checking bench for id_ex_pipe with a reference model;
//                a second instance with CNT_W=2 exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe;

`ifdef HAZARD_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [1:0]  WB_in = '0;
    logic [3:0]  MEM_in = '0;
    logic [6:0]  EX_in = '0;
    logic [31:0] nextAddress_in = '0, A_in = '0, B_in = '0, imm_in = '0;
    logic [4:0]  Ins25_in = '0, Ins20_in = '0, Ins15_in = '0;
    logic [25:0] tar_in = '0;

    logic [1:0]  WB_out, s_WB_out;
    logic [3:0]  MEM_out, s_MEM_out;
    logic [31:0] nextAddress_out, A_out, B_out, imm_out;
    logic [31:0] s_nextAddress_out, s_A_out, s_B_out, s_imm_out;
    logic [4:0]  Ins25_out, Ins20_out, Ins15_out, s_Ins25_out, s_Ins20_out, s_Ins15_out;
    logic [25:0] tar_out, s_tar_out;
    logic        ex_valid, RegDst, ALUSrc, hazard_stall;
    logic        s_ex_valid, s_RegDst, s_ALUSrc, s_hazard_stall;
    logic [1:0]  AluzeroCtr, s_AluzeroCtr;
    logic [2:0]  ALUop, s_ALUop;
    logic [15:0] bubble_cnt;
    logic [1:0]  s_bubble_cnt;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .WB_in(WB_in), .MEM_in(MEM_in), .EX_in(EX_in), .nextAddress_in(nextAddress_in),
        .A_in(A_in), .B_in(B_in), .imm_in(imm_in), .Ins25_in(Ins25_in), .Ins20_in(Ins20_in),
        .Ins15_in(Ins15_in), .tar_in(tar_in), .WB_out(WB_out), .MEM_out(MEM_out),
        .nextAddress_out(nextAddress_out), .A_out(A_out), .B_out(B_out), .imm_out(imm_out),
        .Ins25_out(Ins25_out), .Ins20_out(Ins20_out), .Ins15_out(Ins15_out), .tar_out(tar_out),
        .ex_valid(ex_valid), .AluzeroCtr(AluzeroCtr), .RegDst(RegDst), .ALUop(ALUop),
        .ALUSrc(ALUSrc), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt));

    id_ex_pipe #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .WB_in(WB_in), .MEM_in(MEM_in), .EX_in(EX_in), .nextAddress_in(nextAddress_in),
        .A_in(A_in), .B_in(B_in), .imm_in(imm_in), .Ins25_in(Ins25_in), .Ins20_in(Ins20_in),
        .Ins15_in(Ins15_in), .tar_in(tar_in), .WB_out(s_WB_out), .MEM_out(s_MEM_out),
        .nextAddress_out(s_nextAddress_out), .A_out(s_A_out), .B_out(s_B_out), .imm_out(s_imm_out),
        .Ins25_out(s_Ins25_out), .Ins20_out(s_Ins20_out), .Ins15_out(s_Ins15_out), .tar_out(s_tar_out),
        .ex_valid(s_ex_valid), .AluzeroCtr(s_AluzeroCtr), .RegDst(s_RegDst), .ALUop(s_ALUop),
        .ALUSrc(s_ALUSrc), .hazard_stall(s_hazard_stall), .bubble_cnt(s_bubble_cnt));

    // Reference model: architectural state of the EX stage.
    logic        m_v = 1'b0;
    logic [1:0]  m_wb = '0;
    logic [3:0]  m_mem = '0;
    logic [6:0]  m_ex = '0;
    logic [31:0] m_npc = '0, m_a = '0, m_b = '0, m_imm = '0;
    logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0;
    logic [25:0] m_tar = '0;
    int          m_cnt = 0, m_cnt2 = 0;

    function automatic bit model_hz();
        return HZ_EN && !reset && m_v && m_mem[1] && id_valid && (m_rt != 5'd0) &&
               ((m_rt == Ins25_in) || (m_rt == Ins20_in));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_v = 0; m_wb = '0; m_mem = '0; m_ex = '0; m_npc = '0; m_a = '0; m_b = '0;
            m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_tar = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (flush || (!stall && model_hz())) begin
            m_v = 0; m_wb = '0; m_mem = '0; m_ex = '0;
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
        end else if (!stall) begin
            m_v = id_valid; m_wb = WB_in; m_mem = MEM_in; m_ex = EX_in; m_npc = nextAddress_in;
            m_a = A_in; m_b = B_in; m_imm = imm_in; m_rs = Ins25_in; m_rt = Ins20_in;
            m_rd = Ins15_in; m_tar = tar_in;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #2;
        chk("ex_valid", ex_valid, m_v);
        chk("WB_out", WB_out, m_wb);
        chk("MEM_out", MEM_out, m_mem);
        chk("EX_out", {AluzeroCtr, RegDst, ALUop, ALUSrc}, m_ex);
        chk("data", {nextAddress_out, A_out}, {m_npc, m_a});
        chk("data2", {B_out, imm_out}, {m_b, m_imm});
        chk("regs", {Ins25_out, Ins20_out, Ins15_out, tar_out}, {m_rs, m_rt, m_rd, m_tar});
        chk("hazard_stall", hazard_stall, model_hz());
        chk("bubble_cnt", bubble_cnt, m_cnt);
        chk("small_cnt", s_bubble_cnt, m_cnt2);
        chk("small_valid", {s_ex_valid, s_hazard_stall}, {m_v, model_hz()});
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic drive_rand();
        WB_in = 2'($urandom); MEM_in = 4'($urandom); EX_in = 7'($urandom);
        nextAddress_in = $urandom; A_in = $urandom; B_in = $urandom; imm_in = $urandom;
        Ins25_in = 5'($urandom_range(0, 3)); Ins20_in = 5'($urandom_range(0, 3));
        Ins15_in = 5'($urandom); tar_in = 26'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sat_seq [5];
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset with busy inputs
        drive_rand(); id_valid = 1; A_in = 32'hDEAD_BEEF; EX_in = 7'h7F;
        tick(); tick();
        chk("rst_A", A_out, 32'h0);
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_cnt", bubble_cnt, 16'd0);
        chk("rst_ex", {AluzeroCtr, RegDst, ALUop, ALUSrc}, 7'd0);

        // Plain load
        reset = 0; stall = 0; flush = 0; id_valid = 1;
        WB_in = 2'b01; MEM_in = 4'b0000; EX_in = 7'b1010110; A_in = 32'h1234_5678;
        Ins20_in = 5'd9; Ins25_in = 5'd8;
        tick();
        chk("ld_A", A_out, 32'h1234_5678);
        chk("ld_zctr", AluzeroCtr, 2'b10);
        chk("ld_regdst", RegDst, 1'b1);
        chk("ld_aluop", ALUop, 3'b011);
        chk("ld_alusrc", ALUSrc, 1'b0);
        chk("ld_valid", ex_valid, 1'b1);

        // Stall three cycles with changing inputs
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
            chk("stall_A", A_out, 32'h1234_5678);
            chk("stall_valid", ex_valid, 1'b1);
            chk("stall_zctr", AluzeroCtr, 2'b10);
            chk("stall_cnt", bubble_cnt, 16'd0);
        end

        // Flush wins over stall
        flush = 1;
        tick();
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_ctrl", {WB_out, MEM_out, AluzeroCtr, RegDst, ALUop, ALUSrc}, 13'd0);
        chk("fl_cnt", bubble_cnt, 16'd1);
        chk("fl_A", A_out, 32'h1234_5678);

        // Load-use: lw with rt=5 in EX, ID reads rs=5
        flush = 0; stall = 0; id_valid = 1;
        WB_in = 2'b10; MEM_in = 4'b0010; EX_in = 7'b0000001; Ins25_in = 5'd1; Ins20_in = 5'd5;
        tick();
        Ins25_in = 5'd5; Ins20_in = 5'd7; MEM_in = 4'b0000;
        #1;
        chk("hz_stall", hazard_stall, HZ_EN ? 1'b1 : 1'b0);
        tick();
        chk("hz_valid", ex_valid, HZ_EN ? 1'b0 : 1'b1);
        chk("hz_clear", hazard_stall, 1'b0);
        chk("hz_cnt", bubble_cnt, HZ_EN ? 16'd2 : 16'd1);

        // Same pattern with rt=0 never stalls
        MEM_in = 4'b0010; Ins25_in = 5'd3; Ins20_in = 5'd0;
        tick();
        Ins25_in = 5'd0; Ins20_in = 5'd0;
        #1;
        chk("hz0_stall", hazard_stall, 1'b0);
        tick();
        chk("hz0_valid", ex_valid, 1'b1);
        chk("hz0_cnt", bubble_cnt, HZ_EN ? 16'd2 : 16'd1);

        // Reset in the middle of a stall
        stall = 1; reset = 1;
        tick();
        chk("rst_stall_valid", ex_valid, 1'b0);
        chk("rst_stall_cnt", bubble_cnt, 16'd0);
        reset = 0; stall = 0;

        // Five consecutive flushes: small counter saturates at 3
        flush = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_small", s_bubble_cnt, sat_seq[i]);
            chk("sat_main", bubble_cnt, 16'(i + 1));
        end
        flush = 0;

        // Mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            drive_rand();
            id_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 39) == 0);
            tick();
        end
        reset = 0; flush = 0; stall = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
